// File: rtl/tc_mul_pkg.sv
// rtl/tc_mul_pkg.sv - default widths and signed range helpers for tc_pipe_mul
package tc_mul_pkg;

  localparam int TC_A_W   = 18;
  localparam int TC_B_W   = 17;
  localparam int TC_P_W   = 33;
  localparam int TC_TAG_W = 8;

  // Width of the exact signed product of an a_w x b_w multiply
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic logic signed [63:0] max_of(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] min_of(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // True when v is representable as a w-bit two's complement value
  function automatic logic in_range(input logic signed [63:0] v, input int w);
    return (v >= min_of(w)) && (v <= max_of(w));
  endfunction

  // Clamp v to the w-bit signed range
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    if (v > max_of(w)) return max_of(w);
    if (v < min_of(w)) return min_of(w);
    return v;
  endfunction

endpackage

// File: rtl/tc_mul_stage.sv
// rtl/tc_mul_stage.sv - one valid/ready pipeline register holding data and tag
module tc_mul_stage
  import tc_mul_pkg::*;
#(
  parameter int DW    = 8,
  parameter int TAG_W = TC_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DW-1:0]    data_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [DW-1:0]    data_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             valid_q;
  logic [DW-1:0]    data_q;
  logic [TAG_W-1:0] tag_q;

  // Empty or draining this cycle: a bubble here never blocks upstream
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

  // Load when accepting; payload only changes with a real beat so a stalled output holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
        tag_q  <= tag_i;
      end
    end
  end

endmodule

// File: rtl/tc_pipe_mul.sv
// rtl/tc_pipe_mul.sv - pipelined signed multiplier with round/shift scaling; TC_PIPE_MUL_SAT_EN selects saturation on overflow
module tc_pipe_mul
  import tc_mul_pkg::*;
#(
  parameter int A_W    = TC_A_W,
  parameter int B_W    = TC_B_W,
  parameter int P_W    = TC_P_W,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 1,
  parameter int STAGES = 3,
  parameter int TAG_W  = TC_TAG_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);

  localparam int PF_W    = prod_w(A_W, B_W);
  localparam int R_W     = PF_W + 1;
  localparam int DW      = (PF_W > P_W + 1) ? PF_W : P_W + 1;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [R_W-1:0] RND_C = (ROUND != 0 && SHIFT > 0) ? (R_W'(1) << RND_POS) : '0;

  // Operand word {a, b} -> exact signed product
  function automatic logic [PF_W-1:0] mul(input logic [DW-1:0] x);
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    a = x[PF_W-1 -: A_W];
    b = x[B_W-1:0];
    return PF_W'(a) * PF_W'(b);
  endfunction

  // Product -> {ovf, p}: round with one guard bit, shift, then range-check
  function automatic logic [DW-1:0] scale(input logic [PF_W-1:0] prod);
    logic signed [R_W-1:0] rnd;
    logic signed [63:0]    sh;
    logic                  ovf;
    rnd = $signed({prod[PF_W-1], prod}) + $signed(RND_C);
    rnd = rnd >>> SHIFT;
    sh  = 64'(rnd);
    ovf = !in_range(sh, P_W);
`ifdef TC_PIPE_MUL_SAT_EN
    sh  = saturate(sh, P_W);
`endif
    return DW'({ovf, sh[P_W-1:0]});
  endfunction

  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [DW-1:0]    s_in  [STAGES];
  logic [DW-1:0]    s_out [STAGES];
  logic [TAG_W-1:0] tg    [STAGES+1];

  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign tg[0]       = in_tag;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      if (STAGES == 1) begin : g_all
        assign s_in[k] = scale(mul(DW'({in_a, in_b})));
      end else begin : g_ops
        assign s_in[k] = DW'({in_a, in_b});
      end
    end else if (k == 1 && k == STAGES - 1) begin : g_mul_scale
      assign s_in[k] = scale(mul(s_out[k-1]));
    end else if (k == 1) begin : g_mul
      assign s_in[k] = DW'(mul(s_out[k-1]));
    end else if (k == STAGES - 1) begin : g_scale
      assign s_in[k] = scale(s_out[k-1][PF_W-1:0]);
    end else begin : g_pass
      assign s_in[k] = s_out[k-1];
    end

    tc_mul_stage #(
      .DW    (DW),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk_i   (ap_clk),
      .rst_ni  (ap_rst_n),
      .valid_i (vld[k]),
      .ready_o (rdy[k]),
      .data_i  (s_in[k]),
      .tag_i   (tg[k]),
      .valid_o (vld[k+1]),
      .ready_i (rdy[k+1]),
      .data_o  (s_out[k]),
      .tag_o   (tg[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign out_tag   = tg[STAGES];
  assign out_p     = s_out[STAGES-1][P_W-1:0];
  assign out_ovf   = s_out[STAGES-1][P_W];

  logic unused_last;
  assign unused_last = ^s_out[STAGES-1];

endmodule

// File: tb/tb_tc_pipe_mul.sv
// tb/tb_tc_pipe_mul.sv - directed self-checking bench for tc_pipe_mul
module tb_tc_pipe_mul;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic               ap_rst_n, in_valid, out_ready;
  logic signed [17:0] in_a;
  logic signed [16:0] in_b;
  logic [7:0]         in_tag;

  logic        in_ready0, out_valid0, out_ovf0;
  logic [32:0] out_p0;
  logic [7:0]  out_tag0;
  logic        in_ready1, out_valid1, out_ovf1;
  logic [32:0] out_p1;
  logic [7:0]  out_tag1;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [32:0] out_p2;
  logic [7:0]  out_tag2;

  tc_pipe_mul dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready),
    .out_p(out_p0), .out_tag(out_tag0), .out_ovf(out_ovf0)
  );

  tc_pipe_mul #(.SHIFT(4), .ROUND(1)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready),
    .out_p(out_p1), .out_tag(out_tag1), .out_ovf(out_ovf1)
  );

  tc_pipe_mul #(.SHIFT(4), .ROUND(0)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid2), .out_ready(out_ready),
    .out_p(out_p2), .out_tag(out_tag2), .out_ovf(out_ovf2)
  );

  int          nvec = 0;
  int          nfail = 0;
  logic [41:0] exp_q[$];
  logic        held;
  logic [41:0] held_v;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference for the default configuration: P_W=33, SHIFT=0
  function automatic logic [41:0] model(input logic signed [17:0] a, input logic signed [16:0] b,
                                        input logic [7:0] t);
    longint pr;
    logic   ovf;
    logic [63:0] v;
    pr  = longint'(a) * longint'(b);
    ovf = (pr > 64'sd4294967295) || (pr < -64'sd4294967296);
    v   = pr;
`ifdef TC_PIPE_MUL_SAT_EN
    if (pr > 64'sd4294967295) v = 64'd4294967295;
    else if (pr < -64'sd4294967296) v = -64'sd4294967296;
`endif
    return {ovf, t, v[32:0]};
  endfunction

  // One clock of scoreboarded traffic on dut0
  task automatic cyc(input string name, output logic acc);
    logic [41:0] got;
    #1;
    got = {out_ovf0, out_tag0, out_p0};
    if (held) chk({name, "_hold"}, 64'(got), 64'(held_v));
    held   = out_valid0 && !out_ready;
    held_v = got;
    acc    = in_valid && in_ready0;
    if (acc) exp_q.push_back(model(in_a, in_b, in_tag));
    if (out_valid0 && out_ready) begin
      chk({name, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk(name, 64'(got), 64'(exp_q.pop_front()));
    end
    tick();
  endtask

  initial begin
    logic acc;
    int   nacc;
    int   j;
    ap_rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    held = 1'b0; held_v = '0;
    tick(); tick();
    chk("rst_valid", 64'(out_valid0), 64'd0);
    chk("rst_p", 64'(out_p0), 64'd0);
    chk("rst_tag", 64'(out_tag0), 64'd0);
    chk("rst_ovf", 64'(out_ovf0), 64'd0);
    ap_rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready0), 64'd1);

    // Overflow: (-2^17) * (-2^16) = 2^33
    in_a = 18'h20000; in_b = 17'h10000; in_tag = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ovf_lat2", 64'(out_valid0), 64'd0);
    tick();
    chk("ovf_valid", 64'(out_valid0), 64'd1);
    chk("ovf_flag", 64'(out_ovf0), 64'd1);
`ifdef TC_PIPE_MUL_SAT_EN
    chk("ovf_p", 64'(out_p0), 64'd4294967295);
`else
    chk("ovf_p", 64'(out_p0), 64'd0);
`endif
    chk("ovf_tag", 64'(out_tag0), 64'h5A);
    tick();

    // Rounding: SHIFT=4 with and without ROUND
    in_valid = 1'b1; in_a = 18'sd3; in_b = 17'sd3; in_tag = 8'd1;
    tick();
    in_a = -18'sd3; in_tag = 8'd2;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rnd_p_pos", 64'(out_p1), 64'd1);
    chk("rnd_tag_pos", 64'(out_tag1), 64'd1);
    chk("trunc_p_pos", 64'(out_p2), 64'd0);
    tick();
    chk("rnd_p_neg", 64'(out_p1), 64'h1_FFFF_FFFF);
    chk("rnd_tag_neg", 64'(out_tag1), 64'd2);
    chk("trunc_p_neg", 64'(out_p2), 64'h1_FFFF_FFFF);
    repeat (4) tick();

    // Back-to-back: a=i, b=100, out on cycles 3..12
    for (int e = 1; e <= 14; e++) begin
      if (e <= 10) begin
        in_valid = 1'b1; in_a = 18'(e - 1); in_b = 17'sd100; in_tag = 8'(e - 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("b2b_valid", 64'(e >= 3 && e <= 12), 64'(out_valid0));
      if (e >= 3 && e <= 12) begin
        chk("b2b_p", 64'(out_p0), 64'(100 * (e - 3)));
        chk("b2b_tag", 64'(out_tag0), 64'(e - 3));
      end
    end

    // Backpressure: 5 beats with the output stalled
    out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
    for (int c = 0; c < 4; c++) begin
      in_a = 18'(nacc + 1); in_b = -17'sd7; in_tag = 8'(8'h40 + nacc);
      #1;
      chk("bp_in_ready", 64'(in_ready0), 64'(nacc < 3));
      cyc("bp", acc);
      if (acc) nacc++;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (nacc < 5) begin
        in_valid = 1'b1; in_a = 18'(nacc + 1); in_b = -17'sd7; in_tag = 8'(8'h40 + nacc);
      end else begin
        in_valid = 1'b0;
      end
      cyc("bp", acc);
      if (acc) nacc++;
    end
    chk("bp_accepted", 64'(nacc), 64'd5);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Alternating out_ready under a continuous stream
    j = 0; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      out_ready = (c % 2 == 0);
      in_a = 18'(j * 1234 - 20000); in_b = 17'(77 - j * 321); in_tag = 8'(8'h80 + j);
      cyc("alt", acc);
      if (acc) j++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) cyc("alt", acc);
    chk("alt_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_a = 18'(c + 7); in_b = 17'sd9; in_tag = 8'(c + 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(out_valid0), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid0), 64'd0);
    chk("rst_mid_p", 64'(out_p0), 64'd0);
    chk("rst_mid_tag", 64'(out_tag0), 64'd0);
    exp_q.delete(); held = 1'b0;
    out_ready = 1'b1;
    tick();
    ap_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_no_stale", 64'(out_valid0), 64'd0);
    end
    chk("rst_post_in_ready", 64'(in_ready0), 64'd1);
    in_valid = 1'b1; in_a = -18'sd5; in_b = 17'sd6; in_tag = 8'hEE;
    cyc("post_rst", acc);
    chk("post_rst_acc", 64'(acc), 64'd1);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) cyc("post_rst", acc);
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
